// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 10-line active-low decimal key bank front end.
// The key lines are synchronized and priority encoded (digit 9 wins).
// Press and release are debounced, and each accepted press pushes one BCD
// code into a show-ahead FIFO that the consumer drains with valid/ready.
module keypad_scan_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    key_n,
  output logic [3:0]                    code,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          key_active,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  // Highest pressed index wins; result is only meaningful when a key is down.
  function automatic logic [3:0] prio_enc(input logic [9:0] s);
    logic [3:0] e;
    e = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (s[i] == 1'b0) begin
        e = 4'(i);
      end
    end
    return e;
  endfunction

  logic [9:0]            sync1_r, sync2_r;
  state_t                state_r, state_nxt;
  logic [3:0]            cand_r, cand_nxt;
  logic [CW-1:0]         cnt_r, cnt_nxt;
  logic                  key_active_r;
  logic [3:0]            mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0]       count_r, count_nxt;
  logic                  overflow_r;

  logic                  any_s, match_s, push_s;
  logic [3:0]            enc_s;
  logic                  valid_s, full_s, pop_s, wr_en_s, drop_s;

  assign any_s   = (sync2_r != 10'h3FF);
  assign enc_s   = prio_enc(sync2_r);
  assign match_s = any_s && (enc_s == cand_r);

  assign valid_s = (count_r != {CNTW{1'b0}});
  assign full_s  = (count_r == CNTW'(FIFO_DEPTH));
  assign pop_s   = valid_s & code_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  assign code       = valid_s ? mem_r[rd_ptr_r] : 4'd0;
  assign code_valid = valid_s;
  assign fifo_count = count_r;
  assign key_active = key_active_r;
  assign overflow   = overflow_r;

  // Two-flop synchronizer for the asynchronous key pins; idles at "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 10'h3FF;
      sync2_r <= 10'h3FF;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM next-state: one push per press, release bounce returns to HELD.
  always_comb begin
    state_nxt = state_r;
    cand_nxt  = cand_r;
    cnt_nxt   = cnt_r;
    push_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          cand_nxt  = enc_s;
          cnt_nxt   = CW'(1);
          state_nxt = ST_PRESS_DB;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PRESS_DB: begin
        if (match_s) begin
          if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            push_s    = 1'b1;
            state_nxt = ST_HELD;
          end else begin
            cnt_nxt = cnt_r + CW'(1);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!any_s) begin
          cnt_nxt   = CW'(1);
          state_nxt = ST_REL_DB;
        end else begin
          state_nxt = ST_HELD;
        end
      end
      ST_REL_DB: begin
        if (any_s) begin
          state_nxt = ST_HELD;
        end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, candidate digit, debounce counter and the key_active flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cand_r       <= 4'd0;
      cnt_r        <= {CW{1'b0}};
      key_active_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      cand_r       <= cand_nxt;
      cnt_r        <= cnt_nxt;
      key_active_r <= (state_nxt == ST_HELD) || (state_nxt == ST_REL_DB);
    end
  end

  // Occupancy moves by at most one entry per cycle.
  always_comb begin
    count_nxt = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt = count_r + CNTW'(1);
      2'b01:   count_nxt = count_r - CNTW'(1);
      default: count_nxt = count_r;
    endcase
  end

  // FIFO storage and pointers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 4'd0;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= cand_r;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: per-cycle vector table plus
// hand-written reset and FIFO overflow sequences.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_n;
  logic [3:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] fifo_count;
  logic       key_active;
  logic       overflow;
  logic       clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_count (fifo_count),
    .key_active (key_active),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  // act = 2 means key_active is not compared for that row
  typedef struct {
    logic [9:0] key;
    logic       rdy;
    logic       clr;
    int         n;
    logic       v;
    logic [3:0] c;
    logic [2:0] cnt;
    logic [1:0] act;
    logic       ovf;
  } row_t;

  row_t rows [64];
  int   nrows = 0;
  int   sec_end [4];
  int   ri = 0;

  task automatic add(input logic [9:0] key, input logic rdy, input int n,
                     input logic v, input logic [3:0] c, input logic [2:0] cnt,
                     input logic [1:0] act, input logic ovf);
    rows[nrows] = '{key, rdy, 1'b0, n, v, c, cnt, act, ovf};
    nrows++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " code"},       32'(code),       32'd0);
    chk({tag, " code_valid"}, 32'(code_valid), 32'd0);
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, " key_active"}, 32'(key_active), 32'd0);
    chk({tag, " overflow"},   32'(overflow),   32'd0);
  endtask

  task automatic run_section(input int s);
    for (int r = ri; r < sec_end[s]; r++) begin
      key_n      = rows[r].key;
      code_ready = rows[r].rdy;
      clr_ovf    = rows[r].clr;
      for (int k = 0; k < rows[r].n; k++) begin
        tick();
        chk($sformatf("row%0d.%0d code_valid", r, k), 32'(code_valid), 32'(rows[r].v));
        chk($sformatf("row%0d.%0d code", r, k),       32'(code),       32'(rows[r].c));
        chk($sformatf("row%0d.%0d fifo_count", r, k), 32'(fifo_count), 32'(rows[r].cnt));
        chk($sformatf("row%0d.%0d overflow", r, k),   32'(overflow),   32'(rows[r].ovf));
        if (rows[r].act != 2'd2) begin
          chk($sformatf("row%0d.%0d key_active", r, k), 32'(key_active), 32'(rows[r].act));
        end
      end
    end
    ri = sec_end[s];
  endtask

  task automatic press_release(input logic [9:0] k);
    key_n = k;
    repeat (8) tick();
    key_n = 10'h3FF;
    repeat (8) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] k;
    int         exp_cnt;

    // ---- vector table ----
    // Section 0: key 8 queued with ready low, then key 5 into PRESS_DB
    add(10'h2FF, 1'b0, 5, 1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h2FF, 1'b0, 1, 1'b1, 4'd8, 3'd1, 2'd2, 1'b0);
    add(10'h3FF, 1'b0, 5, 1'b1, 4'd8, 3'd1, 2'd1, 1'b0);
    add(10'h3FF, 1'b0, 3, 1'b1, 4'd8, 3'd1, 2'd0, 1'b0);
    add(10'h3DF, 1'b0, 4, 1'b1, 4'd8, 3'd1, 2'd0, 1'b0);
    sec_end[0] = nrows;
    // Section 1: key 5 still held after reset release -> exactly one code 5
    add(10'h3DF, 1'b1, 5, 1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h3DF, 1'b1, 1, 1'b1, 4'd5, 3'd1, 2'd2, 1'b0);
    add(10'h3DF, 1'b1, 4, 1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 5, 1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 3, 1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    sec_end[1] = nrows;
    // Section 2a: clean press of 7 held for 20 cycles
    add(10'h37F, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h37F, 1'b1, 1,  1'b1, 4'd7, 3'd1, 2'd2, 1'b0);
    add(10'h37F, 1'b1, 14, 1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 3,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    // Section 2b: press bounce on key 3 (low 2, high 1, low 10)
    add(10'h3F7, 1'b1, 2,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h3FF, 1'b1, 1,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h3F7, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h3F7, 1'b1, 1,  1'b1, 4'd3, 3'd1, 2'd2, 1'b0);
    add(10'h3F7, 1'b1, 4,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 3,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    // Section 2c: keys 9+2 together, 9 released, then 2 pressed alone later
    add(10'h1FB, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h1FB, 1'b1, 1,  1'b1, 4'd9, 3'd1, 2'd2, 1'b0);
    add(10'h1FB, 1'b1, 4,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FB, 1'b1, 10, 1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 3,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h3FB, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h3FB, 1'b1, 1,  1'b1, 4'd2, 3'd1, 2'd2, 1'b0);
    add(10'h3FB, 1'b1, 2,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 3,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    // Section 2d: release bounce on key 4 (2-cycle glitch while held)
    add(10'h3EF, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    add(10'h3EF, 1'b1, 1,  1'b1, 4'd4, 3'd1, 2'd2, 1'b0);
    add(10'h3EF, 1'b1, 4,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 2,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3EF, 1'b1, 8,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 5,  1'b0, 4'd0, 3'd0, 2'd1, 1'b0);
    add(10'h3FF, 1'b1, 3,  1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    sec_end[2] = nrows;

    // ---- power-on reset ----
    rst_n      = 1'b0;
    key_n      = 10'h3FF;
    code_ready = 1'b0;
    clr_ovf    = 1'b0;
    repeat (2) tick();
    chk_idle_outputs("por");
    rst_n = 1'b1;

    // ---- reset in the middle of PRESS_DB ----
    run_section(0);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    repeat (2) tick();
    chk_idle_outputs("rst_held");
    rst_n = 1'b1;
    run_section(1);

    // ---- clean press, press bounce, priority, release bounce ----
    run_section(2);

    // ---- overflow: five presses with the consumer stalled ----
    code_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      k = 10'h3FF ^ (10'd1 << i);
      press_release(k);
      exp_cnt = (i < 4) ? i : 4;
      chk($sformatf("ovf_fill%0d count", i), 32'(fifo_count), 32'(exp_cnt));
      chk($sformatf("ovf_fill%0d overflow", i), 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("ovf head valid", 32'(code_valid), 32'd1);
    chk("ovf head code", 32'(code), 32'd1);
    code_ready = 1'b1;
    for (int j = 2; j <= 4; j++) begin
      tick();
      chk($sformatf("ovf pop code%0d", j), 32'(code), 32'(j));
      chk($sformatf("ovf pop count%0d", j), 32'(fifo_count), 32'(5 - j));
    end
    tick();
    code_ready = 1'b0;
    chk("ovf drained valid", 32'(code_valid), 32'd0);
    chk("ovf drained code", 32'(code), 32'd0);
    chk("ovf sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf cleared", 32'(overflow), 32'd0);

    // ---- push into a full FIFO with a simultaneous pop ----
    for (int i = 1; i <= 4; i++) begin
      k = 10'h3FF ^ (10'd1 << i);
      press_release(k);
    end
    chk("refill count", 32'(fifo_count), 32'd4);
    key_n = 10'h3BF;
    repeat (5) tick();
    chk("pre-push count", 32'(fifo_count), 32'd4);
    chk("pre-push code", 32'(code), 32'd1);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    chk("push+pop count", 32'(fifo_count), 32'd4);
    chk("push+pop overflow", 32'(overflow), 32'd0);
    chk("push+pop head", 32'(code), 32'd2);
    key_n = 10'h3FF;
    repeat (8) tick();
    chk("after 6 overflow", 32'(overflow), 32'd0);
    chk("drain head 2", 32'(code), 32'd2);
    code_ready = 1'b1;
    tick();
    chk("drain head 3", 32'(code), 32'd3);
    tick();
    chk("drain head 4", 32'(code), 32'd4);
    tick();
    chk("drain head 6", 32'(code), 32'd6);
    tick();
    chk("drain empty valid", 32'(code_valid), 32'd0);
    chk("drain empty count", 32'(fifo_count), 32'd0);
    code_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Front-end controller for the 10-line decimal key bank. Encodes the active-low key lines by priority into a BCD digit (0-9), debounces press and release, and emits exactly one code per key press.
- Codes are buffered in a small show-ahead FIFO with a valid/ready handshake toward the consumer (display/entry logic).
- Sits between raw key pins and the digit-entry datapath.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples needed to accept a press or release. Legal values are ≥2.
- FIFO_DEPTH, 4: number of code entries. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_n  in  10  raw key lines, active-low. key_n[i]=0 means digit i is pressed.
- code  out  4  BCD digit at the FIFO head. Drives 4'd0 when the FIFO is empty.
- code_valid  out  1  FIFO non-empty.
- code_ready  in  1  consumer accepts the head entry.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries held.
- key_active  out  1  high in HELD or REL_DB.
- overflow  out  1  sticky; set when a press is dropped because the FIFO is full.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the debounce counter clears.
  - Both synchronizer stages go to 10'h3FF (no key).
  - FIFO is emptied, pointers set to 0.
  - Outputs: code=0, code_valid=0, fifo_count=0, key_active=0, overflow=0.
  - Reset during any state discards the in-progress press.
- Synchronizer:
  - key_n passes through a 2-flop synchronizer; all logic below uses the synchronized value s.
- Priority encode (combinational on s):
  - any = (s != 10'h3FF).
  - enc = highest index i with s[i]=0, so digit 9 has the highest priority.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB. cand is a 4-bit register; cnt is the debounce counter.
  - IDLE: if any, set cand=enc, cnt=1, go to PRESS_DB.
  - PRESS_DB, matching sample (any and enc==cand):
    - cnt increments.
    - On the edge where cnt would reach DEBOUNCE_CYCLES, cand is pushed and the FSM goes to HELD.
  - PRESS_DB, non-matching sample (any=0 or enc!=cand): go to IDLE with no push. A change of code restarts detection from IDLE on the next cycle.
  - HELD:
    - While any=1, stay. Additional or changed keys are ignored; there is no auto-repeat.
    - If any=0, set cnt=1 and go to REL_DB.
  - REL_DB:
    - If any=1, go back to HELD (release bounce) with no new push.
    - Else cnt increments; when it would reach DEBOUNCE_CYCLES, go to IDLE.
- Latency: key_n stable low from before edge 0 → push at edge DEBOUNCE_CYCLES+1 → code_valid high after that edge (edge 5 for the default).
- FIFO (show-ahead):
  - pop = code_valid & code_ready.
  - push = the FSM accept event.
  - Not full: push writes at the tail.
  - Full with no pop: push is dropped and overflow is set.
  - Full with a simultaneous pop: both occur, no overflow, and the count is unchanged.
  - Empty: push only. code_valid rises the next cycle; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count changes by +1, -1 or 0 per cycle.
- overflow:
  - Set by a dropped push.
  - Cleared by clr_ovf=1.
  - If a drop occurs in the same cycle as clr_ovf, set wins.
- Consumer handshake: code and code_valid stay stable while code_valid=1 and code_ready=0.

Test Plan:
1. Reset: assert rst_n=0 mid-PRESS_DB with key_n[5]=0 → all outputs 0 immediately. After release of reset with the key still held, exactly one code 5 appears, timed from the reset release.
2. Clean press: key_n[7]=0 for 20 cycles, code_ready=1 → code_valid high for exactly one cycle, after edge 5, with code=7. No further codes; key_active high from edge 6 until release debounce completes.
3. Press bounce: key_n[3] low 2 cycles, high 1, low 10 → a single code 3, pushed 5 edges after the final low edge.
4. Priority: key_n[9] and key_n[2] low together, then key_n[9] released while key_n[2] is still held → one code 9 only. No code 2 until all keys are released and 2 is pressed again.
5. Release bounce: hold key 4 to HELD, glitch it high for 2 cycles, then low again → no second code 4; key_active stays 1.
6. Overflow: code_ready=0, five full press/release cycles of keys 1,2,3,4,5 → fifo_count=4, overflow=1. Popping returns 1,2,3,4 in order; clr_ovf clears overflow. A press of 6 while full, with a simultaneous pop, is accepted and overflow stays 0.
